// File: rtl/switch_input_conditioner_pkg.sv
// Shared constants for the switch input conditioner.
// Top-level defaults for switch count, synchroniser depth and debounce time.
package switch_input_conditioner_pkg;

    // Total raw switch count; the top bit is the program go switch.
    localparam int SWITCH_WIDTH = 10;

    // Flip-flops in each synchroniser chain.
    localparam int SW_SYNC_STAGES = 2;

    // 10 ms at 50 MHz.
    localparam int SW_DEBOUNCE_CYCLES = 500000;

endpackage

// File: rtl/switch_input_conditioner_switch_debounce.sv
// One switch bit: synchroniser chain into clk, then a debounce counter.
// The held value only changes after DEBOUNCE_CYCLES consecutive differing samples.
module switch_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic held
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic                   s;
    logic [CW-1:0]          cnt;

    assign s = sync[SYNC_STAGES-1];

    // Shift the asynchronous pin through the synchroniser chain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], raw};
        end
    end

    // Count consecutive disagreeing samples; accept on the last one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            held <= 1'b0;
            cnt  <= '0;
        end else if (s == held) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            held <= s;
            cnt  <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/switch_input_conditioner.sv
// Conditions the board switches: per-bit sync + debounce, data bus out,
// and the top switch reported as a go level with one-cycle rise/fall pulses.
module switch_input_conditioner
    import switch_input_conditioner_pkg::*;
#(
    parameter int WIDTH           = SWITCH_WIDTH,
    parameter int SYNC_STAGES     = SW_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = SW_DEBOUNCE_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-2:0] sw_data,
    output logic             go_level,
    output logic             go_rise,
    output logic             go_fall
);

    logic [WIDTH-1:0] held;
    logic             go_prev;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        switch_debounce #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_db (
            .clk   (clk),
            .reset (reset),
            .raw   (sw_raw[i]),
            .held  (held[i])
        );
    end

    assign sw_data  = held[WIDTH-2:0];
    assign go_level = held[WIDTH-1];

    // Compare the go level with its previous value to form edge pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            go_prev <= 1'b0;
            go_rise <= 1'b0;
            go_fall <= 1'b0;
        end else begin
            go_prev <= held[WIDTH-1];
            go_rise <= held[WIDTH-1] & ~go_prev;
            go_fall <= ~held[WIDTH-1] & go_prev;
        end
    end

endmodule

// File: tb/tb_switch_input_conditioner.sv
// Scoreboard bench for switch_input_conditioner with a windowed reference model.
// Expected outputs are queued per clock edge and popped by a negedge monitor.
module tb_switch_input_conditioner;

    localparam int W = 10;
    localparam int S = 2;
    localparam int D = 4;

    typedef struct packed {
        logic [W-2:0] data;
        logic         lvl;
        logic         rise;
        logic         fall;
    } exp_t;

    logic         clk    = 1'b0;
    logic         reset  = 1'b1;
    logic [W-1:0] sw_raw = '0;
    logic [W-2:0] sw_data;
    logic         go_level;
    logic         go_rise;
    logic         go_fall;

    int checks = 0;
    int errors = 0;

    exp_t         q[$];
    logic [W-1:0] hist[$];
    logic [W-1:0] mh    = '0;
    logic         mprev = 1'b0;

    switch_input_conditioner #(
        .WIDTH           (W),
        .SYNC_STAGES     (S),
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .sw_raw   (sw_raw),
        .sw_data  (sw_data),
        .go_level (go_level),
        .go_rise  (go_rise),
        .go_fall  (go_fall)
    );

    always #5 clk = ~clk;

    function automatic void model_clear();
        hist.delete();
        for (int i = 0; i < S + D; i++) hist.push_back('0);
        mh    = '0;
        mprev = 1'b0;
    endfunction

    // Reference model: a bit flips once the last D synchronised samples
    // (raw delayed by S edges) all disagree with the held value.
    initial begin
        model_clear();
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                model_clear();
                q.delete();
            end else begin
                logic [W-1:0] nh;
                logic         r;
                logic         f;
                logic         flip;
                hist.push_back(sw_raw);
                r     = mh[W-1] & ~mprev;
                f     = ~mh[W-1] & mprev;
                mprev = mh[W-1];
                nh    = mh;
                for (int b = 0; b < W; b++) begin
                    flip = 1'b1;
                    for (int k = S; k < S + D; k++) begin
                        if (hist[hist.size() - 1 - k][b] == mh[b]) flip = 1'b0;
                    end
                    if (flip) nh[b] = ~mh[b];
                end
                mh = nh;
                q.push_back('{data: mh[W-2:0], lvl: mh[W-1], rise: r, fall: f});
                if (hist.size() > S + D + 4) void'(hist.pop_front());
            end
        end
    end

    // Monitor: one comparison per cycle, away from the active edge.
    initial begin
        exp_t e;
        exp_t a;
        forever begin
            @(negedge clk);
            a = '{data: sw_data, lvl: go_level, rise: go_rise, fall: go_fall};
            if (reset) begin
                e = '0;
            end else if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_empty t=%0t actual=%h", $time, a);
                continue;
            end else begin
                e = q.pop_front();
            end
            checks++;
            if (a !== e || (go_rise && go_fall)) begin
                errors++;
                $display("FAIL outputs t=%0t rst=%0b raw=%h actual data=%h lvl=%0b rise=%0b fall=%0b required data=%h lvl=%0b rise=%0b fall=%0b",
                         $time, reset, sw_raw, a.data, a.lvl, a.rise, a.fall,
                         e.data, e.lvl, e.rise, e.fall);
            end
        end
    end

    task automatic step(input logic [W-1:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            sw_raw = v;
        end
    endtask

    task automatic release_reset();
        @(negedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1;
        reset = 1'b0;
        step('0, 20);

        step(10'h0A5, 12);
        step('0, 12);

        step(10'h008, 3);
        step('0, 10);
        step(10'h008, 6);
        step('0, 12);

        step(10'h200, 10);
        step('0, 10);
        step('0, 4);

        step(10'h3FF, 2);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        checks++;
        if ({sw_data, go_level, go_rise, go_fall} !== '0) begin
            errors++;
            $display("FAIL async_reset actual data=%h lvl=%0b rise=%0b fall=%0b required all 0",
                     sw_data, go_level, go_rise, go_fall);
        end
        repeat (2) @(negedge clk);
        release_reset();
        step(10'h3FF, 12);
        step('0, 12);

        for (int i = 0; i < 25; i++) begin
            logic [W-1:0] v;
            v    = 10'h002;
            v[0] = i[0];
            step(v, 2);
        end
        step('0, 12);

        for (int i = 0; i < 60; i++) begin
            step(W'($urandom), int'($urandom_range(1, 8)));
        end

        step('0, 12);
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/switch_input_conditioner.md
Name: switch_input_conditioner

Overview:
- Conditions the raw board switches before they reach the register file switch multiplexers.
- Per bit, it synchronises each asynchronous switch into clk, then debounces it.
- Data bits go out as a stable bus; the top switch is the program "go" handshake, reported as a debounced level plus one-cycle rise/fall pulses.
- Sits between the board pins and regs (switches input), at the top level of the picoMIPS core.

Parameters:
- WIDTH, `SWITCH_WIDTH, total raw switch count; bit WIDTH-1 is the go switch, bits WIDTH-2:0 are data.
- SYNC_STAGES, 2, flip-flops in each synchroniser chain (>=2).
- DEBOUNCE_CYCLES, 500000, consecutive cycles a synchronised value must differ from the held value before it is accepted (>=1; 10 ms at 50 MHz).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- sw_raw  input  WIDTH  raw switch pins, asynchronous to clk
- sw_data  output  WIDTH-1  debounced data switches, to regs switches input
- go_level  output  1  debounced level of sw_raw[WIDTH-1]
- go_rise  output  1  one-cycle pulse on the go_level 0->1 transition
- go_fall  output  1  one-cycle pulse on the go_level 1->0 transition

Behaviour:
- Reset (async assert, sync release):
  - All synchroniser flops, held values and counters clear to 0.
  - sw_data=0, go_level=0, go_rise=0, go_fall=0.
- Reset mid-count discards all partial debounce progress.
- Synchroniser: each bit passes through SYNC_STAGES flops with no reset-free stages. Call the chain output s[i].
- Debounce per bit, held value h[i] and counter c[i] of width $clog2(DEBOUNCE_CYCLES+1):
  - If s[i]==h[i]: c[i]<=0.
  - Else if c[i]==DEBOUNCE_CYCLES-1: h[i]<=s[i] and c[i]<=0.
  - Else: c[i]<=c[i]+1.
- Any glitch back to h[i] before acceptance restarts the count from 0. A pulse shorter than DEBOUNCE_CYCLES synchronised cycles never reaches the output.
- Latency: a raw change first sampled at edge 1 appears on the outputs after edge SYNC_STAGES+DEBOUNCE_CYCLES.
- Counters never wrap: the maximum value reached is DEBOUNCE_CYCLES-1.
- Outputs: sw_data = h[WIDTH-2:0] and go_level = h[WIDTH-1], all registered.
- go_rise/go_fall:
  - Registered from the edge of h[WIDTH-1] against its previous value.
  - Each asserts for exactly one cycle, in the cycle after go_level changes.
  - They are never both high.
- Independence: bits are fully independent. Simultaneous changes on several bits each complete on their own schedule; there is no cross-bit gating.
- Switch held high through reset release: treated as a normal 0->1 change. go_level rises SYNC_STAGES+DEBOUNCE_CYCLES cycles after release and go_rise fires once.
- Continuous bounce: held value stays put indefinitely and no pulses are emitted.
- X on sw_raw during simulation must not propagate past the counter compare; the bench drives only 0/1.

Decomposition:
- `SWITCH_WIDTH comes from the shared constants file; no new typedefs.
- Add `SW_DEBOUNCE_CYCLES and `SW_SYNC_STAGES to the constants file as the top-level defaults.
- Sub-module switch_debounce: one bit covering the synchroniser, counter and held value, parameterised by SYNC_STAGES and DEBOUNCE_CYCLES.
- switch_input_conditioner generates WIDTH instances and adds the go edge-pulse logic.

Test Plan (bench with WIDTH=10, SYNC_STAGES=2, DEBOUNCE_CYCLES=4):
- Reset, sw_raw=10'h000: after reset release, sw_data=0 and go_level/go_rise/go_fall=0 for 20 cycles.
- sw_raw 0 -> 10'h0A5 held: sw_data stays 0 for 5 edges, becomes 9'h0A5 after edge 6, and stays there.
- sw_raw[3] glitches high for 3 cycles, then returns low: sw_data[3] never rises. A 4-cycle-plus-sync pulse of 6 raw cycles does set sw_data[3].
- sw_raw[9] 0->1 then 1->0, each held 10 cycles: go_level follows at 6-edge latency; go_rise and go_fall each pulse exactly one cycle, once.
- Reset asserted asynchronously 2 cycles into a count on sw_raw=10'h3FF: all outputs drop to 0 immediately, no pulse. After release with sw_raw still 10'h3FF: sw_data=9'h1FF, go_level=1 and one go_rise after 6 edges.
- Bit 0 toggled every 2 cycles for 50 cycles while bit 1 rises once: sw_data[0] is never accepted and stays 0; sw_data[1] rises after 6 edges unaffected.
